tristate_bus_arbiter: RTL and testbench

- Round-robin arbiter and turnaround sequencer for a shared tri-state data bus.
- Grants bus ownership to one of N_REQ requesters and drives the bus from the owner's data; the bus is 'z otherwise.
- Inserts idle turnaround cycles between owners so two drivers never overlap.
- Sits between requesting engines and the shared bus; it replaces ad-hoc enable logic on the tri-state buffers.

---
 rtl/tristate_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_tristate_bus_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tri-state bus, with idle turnaround
// cycles between owners so no two drivers ever overlap.
module tristate_bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 8,
  parameter int TURN_CYC = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DATA_W-1:0]    wdata,
  output logic [N_REQ-1:0]           grant,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       bus_busy,
  output tri   [DATA_W-1:0]          bus
);

  // state   | meaning
  // S_IDLE  | bus unowned, arbitrate on any request
  // S_GRANT | one requester drives the bus
  // S_TURN  | bus released, TURN_CYC idle cycles before the next owner
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_TURN  = 2'd2;

  localparam int OW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURN_CYC + 1);

  logic [1:0]        state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     rr_q, rr_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [TW-1:0]     turn_q, turn_d;
  logic [OW-1:0]     pick_w;
  logic [DATA_W-1:0] own_data;

  function automatic logic [OW-1:0] pick(input logic [N_REQ-1:0] r,
                                         input logic [OW-1:0] ptr);
    logic [OW-1:0] sel;
    logic [OW-1:0] idx;
    logic          found;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = OW'((int'(ptr) + i) % N_REQ);
      if (!found && r[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign pick_w = pick(req, rr_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick_w;
          owner_d = pick_w;
          hold_d  = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        hold_d = hold_q + 1'b1;
        if (!req[owner_q] || hold_q == HW'(MAX_HOLD - 1)) begin
          grant_d = '0;
          rr_d    = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
          turn_d  = '0;
          state_d = S_TURN;
        end
      end
      S_TURN: begin
        if (turn_q == TW'(TURN_CYC - 1)) begin
          if (|req) begin
            grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick_w;
            owner_d = pick_w;
            hold_d  = '0;
            state_d = S_GRANT;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          turn_d = turn_q + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
    end
  end

  always_comb begin
    own_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == OW'(i)) own_data = wdata[i*DATA_W +: DATA_W];
    end
  end

  // Enable follows the registered grant, so an async reset releases the bus at once.
  assign bus      = (|grant_q) ? own_data : {DATA_W{1'bz}};
  assign grant    = grant_q;
  assign owner    = owner_q;
  assign bus_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Scoreboard bench: instance A (MAX_HOLD=2, TURN_CYC=1) and instance B
// (MAX_HOLD=8, TURN_CYC=3) share stimulus; directed expectations are queued per cycle.
module tb_tristate_bus_arbiter;

  localparam logic [31:0] W0 = 32'hD4_A5_B2_C1;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req   = 4'b0000;
  logic [31:0] wdata = W0;
  logic [7:0]  zz;

  wire  [3:0]  grant_a, grant_b;
  wire  [1:0]  owner_a, owner_b;
  wire         busy_a, busy_b;
  tri   [7:0]  bus_a, bus_b;

  tristate_bus_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_HOLD(2), .TURN_CYC(1)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
    .grant(grant_a), .owner(owner_a), .bus_busy(busy_a), .bus(bus_a));

  tristate_bus_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_HOLD(8), .TURN_CYC(3)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
    .grant(grant_b), .owner(owner_b), .bus_busy(busy_b), .bus(bus_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         tag;
    bit         inst;
    logic [3:0] g;
    logic [1:0] o;
    logic       busy;
    logic [7:0] b;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic expect_st(input string name, input bit inst, input logic [3:0] g,
                           input logic [1:0] o, input logic busy, input logic [7:0] b);
    exp_t e;
    e.tag = cyc; e.inst = inst; e.g = g; e.o = o; e.busy = busy; e.b = b; e.name = name;
    q.push_back(e);
  endtask

  task automatic step(input logic [3:0] r);
    @(posedge clk);
    #1;
    req = r;
  endtask

  task automatic do_reset();
    step(4'b0000);
    rst_n = 1'b0;
    step(4'b0000);
    rst_n = 1'b1;
  endtask

  // Monitor: pops expectations due this cycle and checks bus invariants on both instances.
  exp_t       m_e;
  logic [3:0] m_g;
  logic [1:0] m_o;
  logic       m_busy;
  logic [7:0] m_b;
  logic [3:0] prev_a = 4'b0000;
  logic [3:0] prev_b = 4'b0000;

  task automatic check_inv(input string name, input logic [3:0] g, input logic [7:0] b,
                           input logic [3:0] pg);
    n_cmp++;
    if ($countones(g) > 1 || (g == 4'b0000 && b !== zz) ||
        (g != 4'b0000 && pg != 4'b0000 && g != pg)) begin
      n_bad++;
      $display("FAIL inv_%s cyc=%0d: grant=%b prev=%b bus=%h, required onehot/zero grant, z bus when unowned, gap between owners",
               name, cyc, g, pg, b);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].tag <= cyc) begin
      m_e = q.pop_front();
      if (m_e.inst) begin
        m_g = grant_b; m_o = owner_b; m_busy = busy_b; m_b = bus_b;
      end else begin
        m_g = grant_a; m_o = owner_a; m_busy = busy_a; m_b = bus_a;
      end
      n_cmp++;
      if (m_e.tag != cyc || m_g !== m_e.g || m_o !== m_e.o || m_busy !== m_e.busy || m_b !== m_e.b) begin
        n_bad++;
        $display("FAIL %s cyc=%0d: got grant=%b owner=%0d busy=%b bus=%h, want grant=%b owner=%0d busy=%b bus=%h",
                 m_e.name, cyc, m_g, m_o, m_busy, m_b, m_e.g, m_e.o, m_e.busy, m_e.b);
      end
    end
    check_inv("a", grant_a, bus_a, prev_a);
    check_inv("b", grant_b, bus_b, prev_b);
    if ($isunknown(req)) begin
      n_bad++;
      $display("FAIL req_unknown cyc=%0d: req=%b, required known value", cyc, req);
    end
    prev_a = grant_a;
    prev_b = grant_b;
  end

  initial begin
    zz = 'z;

    // reset held with all requests pending
    repeat (3) begin
      step(4'b1111);
      expect_st("reset_hold", 0, 4'b0000, 2'd0, 1'b0, zz);
    end
    step(4'b1111); rst_n = 1'b1;
    expect_st("reset_release", 0, 4'b0000, 2'd0, 1'b0, zz);
    step(4'b0000); expect_st("first_grant", 0, 4'b0001, 2'd0, 1'b1, 8'hC1);
    step(4'b0000); expect_st("first_release", 0, 4'b0000, 2'd0, 1'b1, zz);
    step(4'b0000); expect_st("first_idle", 0, 4'b0000, 2'd0, 1'b0, zz);

    // single requester, dropped after one cycle
    do_reset();
    step(4'b0100); expect_st("single_idle", 0, 4'b0000, 2'd0, 1'b0, zz);
    step(4'b0000); expect_st("single_grant", 0, 4'b0100, 2'd2, 1'b1, 8'hA5);
    step(4'b0000); expect_st("single_turn", 0, 4'b0000, 2'd2, 1'b1, zz);
    step(4'b0000); expect_st("single_idle2", 0, 4'b0000, 2'd2, 1'b0, zz);

    // round robin over 1011 with MAX_HOLD=2
    do_reset();
    step(4'b1011); expect_st("rr_idle", 0, 4'b0000, 2'd0, 1'b0, zz);
    step(4'b1011); expect_st("rr_g0", 0, 4'b0001, 2'd0, 1'b1, 8'hC1);
    step(4'b1011); wdata[7:0] = 8'h3C;
    expect_st("rr_g0_passthru", 0, 4'b0001, 2'd0, 1'b1, 8'h3C);
    step(4'b1011); wdata = W0;
    expect_st("rr_t0", 0, 4'b0000, 2'd0, 1'b1, zz);
    step(4'b1011); expect_st("rr_g1a", 0, 4'b0010, 2'd1, 1'b1, 8'hB2);
    step(4'b1011); expect_st("rr_g1b", 0, 4'b0010, 2'd1, 1'b1, 8'hB2);
    step(4'b1011); expect_st("rr_t1", 0, 4'b0000, 2'd1, 1'b1, zz);
    step(4'b1011); expect_st("rr_g3a", 0, 4'b1000, 2'd3, 1'b1, 8'hD4);
    step(4'b1011); expect_st("rr_g3b", 0, 4'b1000, 2'd3, 1'b1, 8'hD4);
    step(4'b1011); expect_st("rr_t3", 0, 4'b0000, 2'd3, 1'b1, zz);
    step(4'b1011); expect_st("rr_wrap_g0", 0, 4'b0001, 2'd0, 1'b1, 8'hC1);

    // hold limit on instance B: 8 owned, 3 turnaround, 8 owned
    do_reset();
    step(4'b0010); expect_st("hold_idle", 1, 4'b0000, 2'd0, 1'b0, zz);
    for (int k = 0; k < 8; k++) begin
      step(4'b0010); expect_st("hold_grant1", 1, 4'b0010, 2'd1, 1'b1, 8'hB2);
    end
    for (int k = 0; k < 3; k++) begin
      step(4'b0010); expect_st("hold_turn", 1, 4'b0000, 2'd1, 1'b1, zz);
    end
    for (int k = 0; k < 8; k++) begin
      step(4'b0010); expect_st("hold_grant2", 1, 4'b0010, 2'd1, 1'b1, 8'hB2);
    end
    step(4'b0000); expect_st("hold_turn2", 1, 4'b0000, 2'd1, 1'b1, zz);

    // async reset mid-grant, then re-arbitration from pointer 0
    do_reset();
    step(4'b0010); expect_st("ar_idle", 0, 4'b0000, 2'd0, 1'b0, zz);
    step(4'b0000); expect_st("ar_g1", 0, 4'b0010, 2'd1, 1'b1, 8'hB2);
    step(4'b1000); expect_st("ar_t1", 0, 4'b0000, 2'd1, 1'b1, zz);
    step(4'b1000); expect_st("ar_g3", 0, 4'b1000, 2'd3, 1'b1, 8'hD4);
    step(4'b1001); rst_n = 1'b0;
    expect_st("ar_async_release", 0, 4'b0000, 2'd0, 1'b0, zz);
    #5 rst_n = 1'b1;
    step(4'b1001); expect_st("ar_rearb_ptr0", 0, 4'b0001, 2'd0, 1'b1, 8'hC1);

    // random contention; invariants are checked by the monitor every cycle
    do_reset();
    repeat (2000) begin
      @(posedge clk);
      #1;
      req   = 4'($urandom_range(0, 15));
      wdata = $urandom;
    end
    req = 4'b0000;

    repeat (3) @(posedge clk);
    #6;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
